// File: rtl/jstk_pkg.sv
// Shared constants and types for the joystick SPI receiver.
package jstk_pkg;

    localparam int unsigned NUM_BYTES = 5;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned POS_W     = 11;
    localparam int unsigned RAW_W     = 10;
    localparam int unsigned BTN_W     = 3;
    localparam int unsigned ST_W      = 3;
    localparam int unsigned BIT_W     = 3;

    // Receiver FSM state encoding
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ST_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [ST_W-1:0] ST_GAP   = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    // Byte slots in the order the joystick sends them
    localparam logic [BIT_W-1:0] IDX_X_LO = 3'd0;
    localparam logic [BIT_W-1:0] IDX_X_HI = 3'd1;
    localparam logic [BIT_W-1:0] IDX_Y_LO = 3'd2;
    localparam logic [BIT_W-1:0] IDX_Y_HI = 3'd3;
    localparam logic [BIT_W-1:0] IDX_BTN  = 3'd4;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [BTN_W-1:0] buttons;
    } jstk_sample_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Mode-0 SCLK divider: CLK_DIV clocks per half-period, idle low while disabled,
// with one-cycle strobes coinciding with the cycle sclk has just risen/fallen.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (div_q == DW'(CLK_DIV - 1)) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            rise_d = ~sclk_q;
            fall_d = sclk_q;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/jstk_spi_rx.sv
// Periodically polls a joystick over SPI mode 0 and publishes X/Y/buttons
// atomically once all five bytes of a transaction have arrived.
import jstk_pkg::*;

module jstk_spi_rx #(
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned SS_SETUP    = 1500,
    parameter int unsigned POLL_PERIOD = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             miso,
    output logic             mosi,
    output logic             sclk,
    output logic             ss_n,
    output logic [POS_W-1:0] x_val,
    output logic [POS_W-1:0] y_val,
    output logic [BTN_W-1:0] buttons,
    output logic             data_valid,
    output logic             busy
);

    localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned SW = (SS_SETUP > 1) ? $clog2(SS_SETUP) : 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BIT_W-1:0]  byte_q, byte_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [RAW_W-1:0]  xs_q, xs_d;
    logic [RAW_W-1:0]  ys_q, ys_d;
    jstk_sample_t      out_q, out_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              dv_q, dv_d;
    logic              poll_wrap;
    logic              sclk_w, rise_w, fall_w;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_SHIFT),
        .sclk_o (sclk_w),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            poll_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            out_q   <= '0;
            ss_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            out_q   <= out_d;
            ss_n_q  <= ss_n_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shreg_d   = shreg_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        out_d     = out_q;
        ss_n_d    = ss_n_q;
        dv_d      = 1'b0;
        poll_wrap = (poll_q == PW'(POLL_PERIOD - 1));
        poll_d    = poll_wrap ? '0 : poll_q + PW'(1);

        case (state_q)
            ST_IDLE: begin
                // Wraps that find the FSM busy or disabled are simply dropped
                if (poll_wrap && en) begin
                    state_d = ST_SETUP;
                    ss_n_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SETUP, ST_GAP: begin
                if (cnt_q == SW'(SS_SETUP - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            ST_SHIFT: begin
                if (rise_w) begin
                    shreg_d = {shreg_q[BYTE_W-2:0], miso};
                end
                if (fall_w) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        case (byte_q)
                            IDX_X_LO: xs_d[7:0] = shreg_q;
                            IDX_X_HI: xs_d[9:8] = shreg_q[1:0];
                            IDX_Y_LO: ys_d[7:0] = shreg_q;
                            IDX_Y_HI: ys_d[9:8] = shreg_q[1:0];
                            default:  ;
                        endcase
                        if (byte_q == IDX_BTN) begin
                            state_d       = ST_DONE;
                            byte_d        = '0;
                            ss_n_d        = 1'b1;
                            dv_d          = 1'b1;
                            out_d.x       = {1'b0, xs_q};
                            out_d.y       = {1'b0, ys_q};
                            out_d.buttons = shreg_q[BTN_W-1:0];
                        end else begin
                            state_d = ST_GAP;
                            byte_d  = byte_q + 3'd1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = ~ss_n_d;
    end

    assign mosi       = 1'b0;
    assign sclk       = sclk_w;
    assign ss_n       = ss_n_q;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign x_val      = out_q.x;
    assign y_val      = out_q.y;
    assign buttons    = out_q.buttons;

endmodule

// File: tb/tb_jstk_spi_rx.sv
// Directed-plus-random bench for jstk_spi_rx with an SPI slave model and a
// byte-level reference model of the published joystick sample.
module tb_jstk_spi_rx;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned SS_SETUP    = 20;
    localparam int unsigned POLL_PERIOD = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        miso = 1'b0;
    logic        mosi, sclk, ss_n, data_valid, busy;
    logic [10:0] x_val, y_val;
    logic [2:0]  buttons;

    always #5 clk = ~clk;

    jstk_spi_rx #(
        .CLK_DIV     (CLK_DIV),
        .SS_SETUP    (SS_SETUP),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .miso       (miso),
        .mosi       (mosi),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .x_val      (x_val),
        .y_val      (y_val),
        .buttons    (buttons),
        .data_valid (data_valid),
        .busy       (busy)
    );

    logic [7:0]  tx [5];
    int          vectors = 0;
    int          miscompares = 0;

    int          cyc = 0, rises = 0, per_bad = 0, gap_min = 1 << 30;
    int          last_rise = 0, last_edge = 0, ss_falls = 0, dv_cnt = 0;
    int          busy_bad = 0, stab_bad = 0, bit_idx = 0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [24:0] prev_outs = '0;

    // Slave drives MSB first, changing miso after each sclk fall; monitor tallies timing
    always @(negedge clk) begin
        cyc++;
        if (prev_ss && !ss_n) begin
            ss_falls++;
            rises     = 0;
            bit_idx   = 0;
            last_edge = cyc;
        end else if (!ss_n && prev_sclk && !sclk) begin
            bit_idx++;
            last_edge = cyc;
        end
        if (!prev_sclk && sclk) begin
            rises++;
            if ((rises - 1) % 8 == 0) begin
                if (cyc - last_edge < gap_min) gap_min = cyc - last_edge;
            end else if (cyc - last_rise != 2 * CLK_DIV) begin
                per_bad++;
            end
            last_rise = cyc;
        end
        if (!ss_n && bit_idx < 40) miso = tx[3'(bit_idx / 8)][3'(7 - bit_idx % 8)];
        if (data_valid) dv_cnt++;
        if (busy !== !ss_n) busy_bad++;
        if (rst && ({x_val, y_val, buttons} != prev_outs) && !data_valid) stab_bad++;
        prev_outs = {x_val, y_val, buttons};
        prev_ss   = ss_n;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_x();
        return 32'(int'(tx[1] % 8'd4) * 256 + int'(tx[0]));
    endfunction

    function automatic logic [31:0] model_y();
        return 32'(int'(tx[3] % 8'd4) * 256 + int'(tx[2]));
    endfunction

    function automatic logic [31:0] model_b();
        return 32'(tx[4] % 8'd8);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(input string tag);
        int start;
        int n;
        start = dv_cnt;
        n = 0;
        while (dv_cnt == start && n < 3 * POLL_PERIOD) begin
            tick(1);
            n++;
        end
        check({tag, "_dv_seen"}, 32'(dv_cnt != start), 32'd1);
        tick(3);
        check({tag, "_dv_once"}, 32'(dv_cnt - start), 32'd1);
    endtask

    task automatic check_sample(input string tag);
        check({tag, "_x"}, 32'(x_val), model_x());
        check({tag, "_y"}, 32'(y_val), model_y());
        check({tag, "_btn"}, 32'(buttons), model_b());
        check({tag, "_rises"}, 32'(rises), 32'd40);
    endtask

    task automatic measure_first_poll(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        rst = 1'b1;
        while (ss_n && n < 2 * POLL_PERIOD) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n), 32'(POLL_PERIOD));
    endtask

    task automatic randomize_tx();
        for (int i = 0; i < 5; i++) tx[i] = 8'($urandom);
    endtask

    initial begin
        int f0;
        int d0;
        int n;

        tx[0] = 8'hA5; tx[1] = 8'h02; tx[2] = 8'h3C; tx[3] = 8'h01; tx[4] = 8'h05;
        tick(3);
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_x", 32'(x_val), 32'd0);
        check("rst_y", 32'(y_val), 32'd0);
        check("rst_btn", 32'(buttons), 32'd0);

        en = 1'b1;
        measure_first_poll("first_poll");
        wait_dv("known");
        check("known_x", 32'(x_val), 32'h2A5);
        check("known_y", 32'(y_val), 32'h13C);
        check("known_btn", 32'(buttons), 32'h5);
        check("known_rises", 32'(rises), 32'd40);
        check("sclk_period", 32'(per_bad), 32'd0);
        check("setup_gap", 32'(gap_min >= int'(SS_SETUP)), 32'd1);

        for (int t = 0; t < 3; t++) begin
            randomize_tx();
            wait_dv("rand");
            check_sample("rand");
        end

        randomize_tx();
        tx[0] = 8'hFF;
        tx[1] = 8'($urandom) | 8'h03;
        wait_dv("xmax");
        check_sample("xmax");
        check("xmax_bit10", 32'(x_val[10]), 32'd0);
        randomize_tx();
        tx[0] = 8'h00;
        tx[1] = 8'($urandom) & 8'hFC;
        wait_dv("xmin");
        check_sample("xmin");
        check("outs_stable", 32'(stab_bad), 32'd0);
        check("busy_track", 32'(busy_bad), 32'd0);

        en = 1'b0;
        f0 = ss_falls;
        d0 = dv_cnt;
        tick(2 * POLL_PERIOD);
        check("en0_no_ss", 32'(ss_falls - f0), 32'd0);
        check("en0_no_dv", 32'(dv_cnt - d0), 32'd0);

        en = 1'b1;
        randomize_tx();
        f0 = ss_falls;
        n = 0;
        while (!(ss_falls > f0 && rises >= 10) && n < 3 * POLL_PERIOD) begin
            tick(1);
            n++;
        end
        check("byte1_reached", 32'(rises >= 10), 32'd1);
        en = 1'b0;
        wait_dv("endrop");
        check_sample("endrop");
        f0 = ss_falls;
        tick(POLL_PERIOD + 50);
        check("endrop_no_more", 32'(ss_falls - f0), 32'd0);

        en = 1'b1;
        randomize_tx();
        f0 = ss_falls;
        n = 0;
        while (!(ss_falls > f0 && rises >= 20) && n < 3 * POLL_PERIOD) begin
            tick(1);
            n++;
        end
        check("byte2_reached", 32'(rises >= 20), 32'd1);
        d0 = dv_cnt;
        rst = 1'b0;
        #1;
        check("abort_ss_n", 32'(ss_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_x", 32'(x_val), 32'd0);
        check("abort_y", 32'(y_val), 32'd0);
        check("abort_btn", 32'(buttons), 32'd0);
        tick(5);
        check("abort_no_dv", 32'(dv_cnt - d0), 32'd0);
        randomize_tx();
        measure_first_poll("repoll");
        wait_dv("after_rst");
        check_sample("after_rst");
        check("final_period", 32'(per_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
